// File: rtl/game_state_controller.sv
// game_state_controller: sequences title, play, death pause, respawn and game over around the Goomba lose flag
// Optional build macro: LOSE_FILTER_EN (lose must stay high LOSE_FILTER_CYCLES consecutive cycles to cost a life).
module game_state_controller #(
    parameter int unsigned START_LIVES        = 3,
    parameter int unsigned DEATH_CYCLES       = 25_000_000,
    parameter int unsigned RESPAWN_CYCLES     = 4,
    parameter int unsigned LOSE_FILTER_CYCLES = 3
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       lose,
    input  logic       start,
    output logic       mover_reset,
    output logic       freeze,
    output logic       game_over,
    output logic [2:0] lives,
    output logic [2:0] state,
    output logic [4:0] leds
);
    localparam logic [2:0] S_TITLE     = 3'd0;
    localparam logic [2:0] S_PLAYING   = 3'd1;
    localparam logic [2:0] S_DYING     = 3'd2;
    localparam logic [2:0] S_RESPAWN   = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;
    localparam logic [2:0] LIVES_INIT   = 3'(START_LIVES);
    localparam logic [31:0] DEATH_LAST   = 32'(DEATH_CYCLES - 1);
    localparam logic [31:0] RESPAWN_LAST = 32'(RESPAWN_CYCLES - 1);

    if (START_LIVES < 1 || START_LIVES > 7) begin : g_bad_start_lives
        $error("START_LIVES must be 1..7");
    end
    if (DEATH_CYCLES < 1 || RESPAWN_CYCLES < 1 || LOSE_FILTER_CYCLES < 1) begin : g_bad_cycles
        $error("cycle parameters must be at least 1");
    end

    logic [2:0]  state_q, state_d;
    logic [2:0]  lives_q, lives_d;
    logic [31:0] cnt_q, cnt_d;
    logic        start_prev_q;
    logic        mover_reset_q, mover_reset_d;
    logic        freeze_q, freeze_d;
    logic        game_over_q, game_over_d;
    logic        start_rise;
    logic        lose_hit;

    assign start_rise = start & ~start_prev_q;

`ifdef LOSE_FILTER_EN
    localparam logic [31:0] FILT_LAST = 32'(LOSE_FILTER_CYCLES - 1);
    logic [31:0] filt_q, filt_d;

    assign lose_hit = lose && (filt_q == FILT_LAST);

    // Count consecutive lose cycles while playing; any gap or non-playing cycle restarts the count
    always_comb begin
        filt_d = (state_q == S_PLAYING && lose && !lose_hit) ? filt_q + 32'd1 : 32'd0;
    end

    // Filter counter register
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) filt_q <= 32'd0;
        else        filt_q <= filt_d;
    end
`else
    assign lose_hit = lose;
`endif

    // State, lives, timer and registered outputs
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_TITLE;
            lives_q       <= LIVES_INIT;
            cnt_q         <= 32'd0;
            start_prev_q  <= 1'b1;
            mover_reset_q <= 1'b1;
            freeze_q      <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            cnt_q         <= cnt_d;
            start_prev_q  <= start;
            mover_reset_q <= mover_reset_d;
            freeze_q      <= freeze_d;
            game_over_q   <= game_over_d;
        end
    end

    // Next state, life accounting and pause/respawn timing
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_TITLE: begin
                cnt_d = 32'd0;
                if (start_rise) state_d = S_PLAYING;
            end
            S_PLAYING: begin
                cnt_d = 32'd0;
                if (lose_hit) begin
                    state_d = S_DYING;
                    lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                end
            end
            S_DYING: begin
                cnt_d = (cnt_q == DEATH_LAST) ? 32'd0 : cnt_q + 32'd1;
                if (cnt_q == DEATH_LAST) state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_RESPAWN;
            end
            S_RESPAWN: begin
                cnt_d = (cnt_q == RESPAWN_LAST) ? 32'd0 : cnt_q + 32'd1;
                if (cnt_q == RESPAWN_LAST) state_d = S_PLAYING;
            end
            S_GAME_OVER: begin
                cnt_d = 32'd0;
                if (start_rise) begin
                    state_d = S_TITLE;
                    lives_d = LIVES_INIT;
                end
            end
            default: begin
                state_d = S_TITLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Moore outputs decoded from the next state so they land in the same cycle as the state change
    always_comb begin
        mover_reset_d = (state_d == S_TITLE) || (state_d == S_RESPAWN);
        freeze_d      = state_d != S_PLAYING;
        game_over_d   = state_d == S_GAME_OVER;
    end

    assign mover_reset = mover_reset_q;
    assign freeze      = freeze_q;
    assign game_over   = game_over_q;
    assign lives       = lives_q;
    assign state       = state_q;
    assign leds        = {lives_q[1:0], state_q};
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: scoreboard bench for game_state_controller (START_LIVES=2, DEATH=8, RESPAWN=2, FILTER=3)
module tb_game_state_controller;
    localparam logic [2:0] S_TITLE     = 3'd0;
    localparam logic [2:0] S_PLAYING   = 3'd1;
    localparam logic [2:0] S_DYING     = 3'd2;
    localparam logic [2:0] S_RESPAWN   = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;
    localparam int FILT = 3;

    typedef struct {
        logic [2:0] st;
        logic [2:0] lv;
        string      tag;
    } exp_t;

    logic       vga_clock = 1'b0;
    logic       reset;
    logic       lose;
    logic       start;
    logic       mover_reset;
    logic       freeze;
    logic       game_over;
    logic [2:0] lives;
    logic [2:0] state;
    logic [4:0] leds;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    game_state_controller #(
        .START_LIVES       (2),
        .DEATH_CYCLES      (8),
        .RESPAWN_CYCLES    (2),
        .LOSE_FILTER_CYCLES(FILT)
    ) dut (
        .vga_clock  (vga_clock),
        .reset      (reset),
        .lose       (lose),
        .start      (start),
        .mover_reset(mover_reset),
        .freeze     (freeze),
        .game_over  (game_over),
        .lives      (lives),
        .state      (state),
        .leds       (leds)
    );

    always #5 vga_clock = ~vga_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st, input logic [2:0] lv);
        check({tag, ":state"}, 32'(state), 32'(st));
        check({tag, ":lives"}, 32'(lives), 32'(lv));
        check({tag, ":mover_reset"}, 32'(mover_reset), 32'(st == S_TITLE || st == S_RESPAWN));
        check({tag, ":freeze"}, 32'(freeze), 32'(st != S_PLAYING));
        check({tag, ":game_over"}, 32'(game_over), 32'(st == S_GAME_OVER));
        check({tag, ":leds"}, 32'(leds), 32'({lv[1:0], st}));
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge
    task automatic cyc(input logic l, input logic s, input logic [2:0] st, input logic [2:0] lv, input string tag);
        exp_t x;
        @(negedge vga_clock);
        lose  = l;
        start = s;
        x.st  = st;
        x.lv  = lv;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    // Lose a life from PLAYING; the filtered build needs lose held for the full filter length
    task automatic kill(input logic s, input logic [2:0] lv_before, input logic [2:0] lv_after, input string tag);
`ifdef LOSE_FILTER_EN
        repeat (FILT - 1) cyc(1'b1, s, S_PLAYING, lv_before, {tag, "_filt"});
`endif
        cyc(1'b1, s, S_DYING, lv_after, tag);
    endtask

    always @(posedge vga_clock) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_outputs(e.tag, e.st, e.lv);
        end
    end

    initial begin
        reset = 1'b0;
        lose  = 1'b0;
        start = 1'b0;
        @(negedge vga_clock);
        check_outputs("por", S_TITLE, 3'd2);
        reset = 1'b1;

        repeat (4) cyc(1'b0, 1'b0, S_TITLE, 3'd2, "title_idle");
        cyc(1'b0, 1'b1, S_PLAYING, 3'd2, "start_rise");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd2, "play");
        cyc(1'b0, 1'b1, S_PLAYING, 3'd2, "play_start_ignored");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd2, "play");

        kill(1'b0, 3'd2, 3'd1, "death1");
        for (int i = 0; i < 7; i++) cyc(1'b1, i == 3, S_DYING, 3'd1, "dying1");
        cyc(1'b1, 1'b0, S_RESPAWN, 3'd1, "respawn_enter");
        cyc(1'b1, 1'b0, S_RESPAWN, 3'd1, "respawn_stale_lose");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd1, "respawn_done");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd1, "play2");

        kill(1'b1, 3'd1, 3'd0, "death2_with_start");
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, S_DYING, 3'd0, "dying2");
        cyc(1'b0, 1'b1, S_GAME_OVER, 3'd0, "game_over");
        cyc(1'b0, 1'b1, S_GAME_OVER, 3'd0, "go_start_held");
        cyc(1'b0, 1'b0, S_GAME_OVER, 3'd0, "go_release");
        cyc(1'b0, 1'b1, S_TITLE, 3'd2, "go_to_title");
        cyc(1'b0, 1'b0, S_TITLE, 3'd2, "title_again");

        @(negedge vga_clock);
        reset = 1'b0;
        start = 1'b1;
        #1 check_outputs("reset_start_held", S_TITLE, 3'd2);
        @(negedge vga_clock);
        reset = 1'b1;
        repeat (3) cyc(1'b0, 1'b1, S_TITLE, 3'd2, "held_through_reset");
        cyc(1'b0, 1'b0, S_TITLE, 3'd2, "held_release");
        cyc(1'b0, 1'b1, S_PLAYING, 3'd2, "fresh_rise");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd2, "play3");

        kill(1'b0, 3'd2, 3'd1, "death3");
        repeat (4) cyc(1'b0, 1'b0, S_DYING, 3'd1, "dying3");
        @(posedge vga_clock);
        #3 reset = 1'b0;
        #1 check_outputs("async_reset", S_TITLE, 3'd2);
        @(negedge vga_clock);
        check_outputs("reset_held", S_TITLE, 3'd2);
        reset = 1'b1;
        cyc(1'b0, 1'b0, S_TITLE, 3'd2, "after_reset");

`ifdef LOSE_FILTER_EN
        cyc(1'b0, 1'b1, S_PLAYING, 3'd2, "filt_start");
        cyc(1'b1, 1'b0, S_PLAYING, 3'd2, "filt_a1");
        cyc(1'b1, 1'b0, S_PLAYING, 3'd2, "filt_a2");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd2, "filt_gap");
        cyc(1'b1, 1'b0, S_PLAYING, 3'd2, "filt_b1");
        cyc(1'b1, 1'b0, S_PLAYING, 3'd2, "filt_b2");
        cyc(1'b0, 1'b0, S_PLAYING, 3'd2, "filt_gap2");
        cyc(1'b1, 1'b0, S_PLAYING, 3'd2, "filt_c1");
        cyc(1'b1, 1'b0, S_PLAYING, 3'd2, "filt_c2");
        cyc(1'b1, 1'b0, S_DYING, 3'd1, "filt_c3");
        cyc(1'b0, 1'b0, S_DYING, 3'd1, "filt_dying");
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge vga_clock);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Sequences a round of play around the lose flag that the Goomba mover produces; sits directly downstream of it.
- Tracks lives and drives the death pause, respawn reset pulse, title screen and game-over screen.
- Outputs mover_reset and freeze feed back to the Mario and Goomba movers; game_over and state feed the renderer and the LEDs.

Parameters:
- START_LIVES, 3: lives loaded at reset and on leaving GAME_OVER (1..7).
- DEATH_CYCLES, 25_000_000: vga_clock cycles spent in DYING (≥1). The default is 1 s at 25 MHz.
- RESPAWN_CYCLES, 4: cycles mover_reset is held high in RESPAWN (≥1).
- LOSE_FILTER_CYCLES, 3: consecutive cycles lose must be high; used only with LOSE_FILTER_EN.

Ports:
- vga_clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state when 0.
- lose  in  1  level from GoombaMover: Mario overlaps a Goomba.
- start  in  1  level, player start button; edge-detected internally.
- mover_reset  out  1  active-high reset to the Mario and Goomba movers.
- freeze  out  1  high means movers must ignore left/right/jump.
- game_over  out  1  high only in GAME_OVER.
- lives  out  3  remaining lives.
- state  out  3  TITLE=0, PLAYING=1, DYING=2, RESPAWN=3, GAME_OVER=4.
- leds  out  5  {lives[1:0], state[2:0]}.

Behaviour:
- All outputs are registered, Moore style. Each output reflects the state register, so outputs change 1 cycle after the input event.
- Reset (reset=0, async) sets:
  - state=TITLE, lives=START_LIVES.
  - mover_reset=1, freeze=1, game_over=0.
  - counter=0.
  - start_prev=1, so a start held through reset does not start the game.
- start_rise = start & ~start_prev. start_prev updates every cycle.
- TITLE: mover_reset=1, freeze=1. On start_rise → PLAYING.
- PLAYING: mover_reset=0, freeze=0.
  - lose (or the filtered lose) high → DYING.
  - On that transition, lives decrements, saturating at 0, and counter clears.
  - start is ignored in PLAYING, including when start and lose arrive in the same cycle.
- DYING: freeze=1, mover_reset=0.
  - Counter increments each cycle.
  - When counter == DEATH_CYCLES-1: counter clears, then → GAME_OVER if lives==0, else → RESPAWN.
  - lose and start are ignored.
- RESPAWN: mover_reset=1, freeze=1.
  - Counter increments each cycle.
  - When counter == RESPAWN_CYCLES-1: counter clears and → PLAYING.
  - mover_reset is therefore high for exactly RESPAWN_CYCLES cycles.
  - lose is ignored, including a stale lose that is still high.
- GAME_OVER: game_over=1, freeze=1, mover_reset=0.
  - On start_rise → TITLE and lives reloads to START_LIVES.
- Counter is 32-bit unsigned and never exceeds max(DEATH_CYCLES, RESPAWN_CYCLES)-1.
- Illegal state codes 5–7 → TITLE on the next clock.
- Reset asserted mid-DYING or mid-RESPAWN forces the reset values immediately; no pending decrement survives.

Optional Feature:
- LOSE_FILTER_EN defined:
  - PLAYING leaves only after lose has been high for LOSE_FILTER_CYCLES consecutive cycles.
  - A filter counter clears whenever lose=0 and on every entry to PLAYING.
- Undefined: a single-cycle lose in PLAYING triggers DYING. The filter logic is absent.

Test Plan:
Run with START_LIVES=2, DEATH_CYCLES=8, RESPAWN_CYCLES=2, LOSE_FILTER_CYCLES=3.
1. Reset release, start rise at cycle 5 → state=1 at cycle 6; mover_reset and freeze drop to 0 in the same cycle; lives=2.
2. PLAYING, 1-cycle lose pulse → state=2 next cycle, lives=1, freeze=1. After 8 cycles, state=3 with mover_reset=1 for exactly 2 cycles, then state=1.
3. Second lose → DYING with lives=0 → after 8 cycles state=4, game_over=1. start held high → nothing; release then press → state=0, lives=2.
4. start held high through reset release → remains TITLE until start goes low and rises again.
5. reset pulled low for 1 cycle mid-DYING (counter=4) → outputs return to reset values asynchronously, lives=2.
6. LOSE_FILTER_EN defined: lose high 2 cycles, low, high 2 cycles → stays PLAYING. lose high 3 cycles → DYING on the following cycle.
